// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the serializer front end of the sequence-detector chain.
package bit_serializer_pkg;

    typedef enum logic {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_e;

    localparam logic IDLE_BIT_DEFAULT = 1'b0;
    localparam int   FIFO_DEPTH       = 2;

endpackage

// File: rtl/bit_serializer_word_fifo2.sv
// Two-entry word buffer that decouples the producer handshake from the shifter.
module word_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] head_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             rdPtr_q;
    logic             wrPtr_q;
    logic [1:0]       count_q;
    logic             pushOk;
    logic             popOk;

    // A push into a full buffer is only legal when the head leaves at the same edge.
    assign pushOk  = push_i && ((count_q != 2'd2) || pop_i);
    assign popOk   = pop_i && (count_q != 2'd0);
    assign head_o  = mem_q[rdPtr_q];
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rdPtr_q <= 1'b0;
            wrPtr_q <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (pushOk) wrPtr_q <= ~wrPtr_q;
            if (popOk)  rdPtr_q <= ~rdPtr_q;
            count_q <= count_q + {1'b0, pushOk} - {1'b0, popOk};
        end
    end

    always_ff @(posedge clk) begin
        if (pushOk) mem_q[wrPtr_q] <= data_i;
    end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: buffers up to two words and shifts them out one bit per clock.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = IDLE_BIT_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    ser_state_e       state_q, state_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic [WIDTH-1:0] shiftReg_q, shiftReg_d;
    logic             serOut_q, serOut_d;
    logic             serValid_q, serValid_d;
    logic             frameStart_q, frameStart_d;
    logic             inReady_q;
    logic             push;
    logic             pop;
    logic             loadWord;
    logic [WIDTH-1:0] head;
    logic [1:0]       count;
    logic [1:0]       countNext;

    function automatic logic firstBit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] shiftOnce(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    assign push = in_valid && inReady_q;

    word_fifo2 #(.WIDTH(WIDTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (in_data),
        .head_o  (head),
        .count_o (count)
    );

    // in_ready looks at the occupancy after this edge so a full buffer never over-accepts.
    assign countNext = count + {1'b0, push} - {1'b0, pop};

    always_comb begin
        state_d      = state_q;
        bcnt_d       = bcnt_q;
        shiftReg_d   = shiftReg_q;
        serOut_d     = IDLE_BIT;
        serValid_d   = 1'b0;
        frameStart_d = 1'b0;
        pop          = 1'b0;
        loadWord     = 1'b0;

        case (state_q)
            SER_IDLE: begin
                if (count != 2'd0) loadWord = 1'b1;
            end
            SER_SHIFT: begin
                if (bcnt_q == LAST_BIT) begin
                    if (count != 2'd0) loadWord = 1'b1;
                    else               state_d  = SER_IDLE;
                end else begin
                    serOut_d   = firstBit(shiftReg_q);
                    shiftReg_d = shiftOnce(shiftReg_q);
                    bcnt_d     = bcnt_q + 1'b1;
                    serValid_d = 1'b1;
                end
            end
            default: state_d = SER_IDLE;
        endcase

        // Loading shows the head's first bit immediately, keeping back-to-back words gapless.
        if (loadWord) begin
            pop          = 1'b1;
            state_d      = SER_SHIFT;
            bcnt_d       = '0;
            serOut_d     = firstBit(head);
            shiftReg_d   = shiftOnce(head);
            serValid_d   = 1'b1;
            frameStart_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= SER_IDLE;
            bcnt_q       <= '0;
            shiftReg_q   <= '0;
            serOut_q     <= IDLE_BIT;
            serValid_q   <= 1'b0;
            frameStart_q <= 1'b0;
            inReady_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bcnt_q       <= bcnt_d;
            shiftReg_q   <= shiftReg_d;
            serOut_q     <= serOut_d;
            serValid_q   <= serValid_d;
            frameStart_q <= frameStart_d;
            inReady_q    <= (countNext < 2'd2);
        end
    end

    assign in_ready    = inReady_q;
    assign ser_out     = serOut_q;
    assign ser_valid   = serValid_q;
    assign frame_start = frameStart_q;
    assign busy        = (state_q == SER_SHIFT) || (count != 2'd0);

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench: MSB-first and LSB-first serializers driven in lockstep against a queue model.
module tb_bit_serializer;

    localparam int   WIDTH    = 8;
    localparam logic IDLE_LVL = 1'b0;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [WIDTH-1:0] inData = '0;
    logic             inValid = 1'b0;

    logic inReadyM, serOutM, serValidM, frameStartM, busyM;
    logic inReadyL, serOutL, serValidL, frameStartL, busyL;

    bit_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1), .IDLE_BIT(IDLE_LVL)) dutM (
        .clk(clk), .reset(reset), .in_data(inData), .in_valid(inValid),
        .in_ready(inReadyM), .ser_out(serOutM), .ser_valid(serValidM),
        .frame_start(frameStartM), .busy(busyM)
    );

    bit_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0), .IDLE_BIT(IDLE_LVL)) dutL (
        .clk(clk), .reset(reset), .in_data(inData), .in_valid(inValid),
        .in_ready(inReadyL), .ser_out(serOutL), .ser_valid(serValidL),
        .frame_start(frameStartL), .busy(busyL)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: a word queue plus the index of the bit currently on the wire (-1 = idle).
    logic [WIDTH-1:0] mQ[$];
    logic [WIDTH-1:0] mCur = '0;
    int               mIdx = -1;
    bit               mReady = 1'b0;
    bit               mAcc;

    always @(posedge clk) begin
        if (!reset) begin
            mQ.delete();
            mIdx   = -1;
            mReady = 1'b0;
        end else begin
            mAcc = inValid && mReady;
            if ((mIdx < 0 || mIdx == WIDTH - 1) && mQ.size() > 0) begin
                mCur = mQ.pop_front();
                mIdx = 0;
            end else if (mIdx == WIDTH - 1) begin
                mIdx = -1;
            end else if (mIdx >= 0) begin
                mIdx++;
            end
            if (mAcc) mQ.push_back(inData);
            mReady = (mQ.size() < 2);
        end
    end

    function automatic logic expBit(input bit msbFirst);
        if (mIdx < 0) return IDLE_LVL;
        return msbFirst ? mCur[WIDTH-1-mIdx] : mCur[mIdx];
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        logic expValid, expBusy;
        expValid = (mIdx >= 0);
        expBusy  = (mIdx >= 0) || (mQ.size() > 0);
        checkVal("readyM",  inReadyM,    mReady);
        checkVal("outM",    serOutM,     expBit(1'b1));
        checkVal("validM",  serValidM,   expValid);
        checkVal("frameM",  frameStartM, (mIdx == 0));
        checkVal("busyM",   busyM,       expBusy);
        checkVal("readyL",  inReadyL,    mReady);
        checkVal("outL",    serOutL,     expBit(1'b0));
        checkVal("validL",  serValidL,   expValid);
        checkVal("frameL",  frameStartL, (mIdx == 0));
        checkVal("busyL",   busyL,       expBusy);
    endtask

    // Observers for run length, received words and activity counts on the MSB-first stream.
    int               runLen = 0, lastRun = 0, validSeen = 0, frameSeen = 0;
    logic [WIDTH-1:0] rxBits = '0;
    int               rxCnt = 0;
    logic [WIDTH-1:0] rxQ[$];

    task automatic step();
        @(posedge clk);
        #1;
        checkOutput();
        if (serValidM) begin
            runLen++;
            validSeen++;
            if (frameStartM) begin
                frameSeen++;
                rxCnt = 0;
            end
            rxBits = {rxBits[WIDTH-2:0], serOutM};
            rxCnt++;
            if (rxCnt == WIDTH) begin
                rxQ.push_back(rxBits);
                rxCnt = 0;
            end
        end else begin
            if (runLen > 0) lastRun = runLen;
            runLen = 0;
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [WIDTH-1:0] data);
        inValid = valid;
        inData  = data;
    endtask

    task automatic pushWord(input logic [WIDTH-1:0] w, output int stalls);
        logic rdy;
        bit   done;
        stalls = 0;
        done   = 1'b0;
        applyStimulus(1'b1, w);
        for (int i = 0; i < 30 && !done; i++) begin
            rdy = inReadyM;
            step();
            if (rdy) done = 1'b1;
            else     stalls++;
        end
        if (!done) checkVal("pushTimeout", 32'd0, 32'd1);
    endtask

    task automatic waitIdle();
        bit idle;
        idle = 1'b0;
        applyStimulus(1'b0, '0);
        for (int i = 0; i < 50 && !idle; i++) begin
            step();
            idle = !busyM && !busyL;
        end
        if (!idle) checkVal("idleTimeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [WIDTH-1:0] word;
        logic [WIDTH-1:0] seqMsb;
        logic [WIDTH-1:0] seqLsb;
    } vec_t;

    vec_t             vecs[4];
    logic [WIDTH-1:0] expWords[$];
    int               stalls;
    int               maxStall;

    initial begin
        // Expected bit sequences, first bit on the wire held in bit 7.
        vecs[0] = '{word: 8'hB0, seqMsb: 8'b1011_0000, seqLsb: 8'b0000_1101};
        vecs[1] = '{word: 8'h0D, seqMsb: 8'b0000_1101, seqLsb: 8'b1011_0000};
        vecs[2] = '{word: 8'hFF, seqMsb: 8'b1111_1111, seqLsb: 8'b1111_1111};
        vecs[3] = '{word: 8'h69, seqMsb: 8'b0110_1001, seqLsb: 8'b1001_0110};

        reset = 1'b0;
        step();
        step();
        checkVal("rstReady", inReadyM, 1'b0);
        checkVal("rstValid", serValidM, 1'b0);
        checkVal("rstBusy",  busyM, 1'b0);
        reset = 1'b1;
        step();
        checkVal("readyAfterRelease", inReadyM, 1'b1);

        // Single words: two-edge latency, bit order for both orders, frame_start on first bit only.
        for (int v = 0; v < 4; v++) begin
            waitIdle();
            pushWord(vecs[v].word, stalls);
            applyStimulus(1'b0, '0);
            checkVal("latencyNoBitYet", serValidM, 1'b0);
            for (int b = 0; b < WIDTH; b++) begin
                step();
                checkVal("tblBitM",   serOutM,     vecs[v].seqMsb[WIDTH-1-b]);
                checkVal("tblBitL",   serOutL,     vecs[v].seqLsb[WIDTH-1-b]);
                checkVal("tblFrameM", frameStartM, (b == 0));
            end
            step();
            checkVal("tblEndValid", serValidM, 1'b0);
        end

        // Back-to-back words form one gapless 24-bit run.
        waitIdle();
        rxQ.delete();
        runLen = 0;
        pushWord(8'hB0, stalls);
        pushWord(8'h0B, stalls);
        pushWord(8'hFF, stalls);
        checkVal("fullReady", inReadyM, 1'b0);
        applyStimulus(1'b0, '0);
        for (int i = 0; i < 40 && serValidM; i++) step();
        checkVal("runLength", lastRun, 24);
        checkVal("b2bCount", rxQ.size(), 3);
        expWords = '{8'hB0, 8'h0B, 8'hFF};
        for (int i = 0; i < 3 && i < rxQ.size(); i++) checkVal("b2bWord", rxQ[i], expWords[i]);

        // Producer stalls on a full buffer; nothing lost or duplicated.
        waitIdle();
        rxQ.delete();
        pushWord(8'hA5, stalls);
        pushWord(8'h3C, stalls);
        pushWord(8'hE7, stalls);
        pushWord(8'h5A, stalls);
        checkVal("stallAtLeast5", (stalls >= 5), 1'b1);
        pushWord(8'hC3, stalls);
        waitIdle();
        expWords = '{8'hA5, 8'h3C, 8'hE7, 8'h5A, 8'hC3};
        checkVal("stallCount", rxQ.size(), 5);
        for (int i = 0; i < 5 && i < rxQ.size(); i++) checkVal("stallWord", rxQ[i], expWords[i]);

        // Reset during the third bit with a word buffered.
        waitIdle();
        pushWord(8'hB0, stalls);
        pushWord(8'h0B, stalls);
        applyStimulus(1'b0, '0);
        step();
        step();
        reset = 1'b0;
        step();
        checkVal("midRstOut",   serOutM,   IDLE_LVL);
        checkVal("midRstValid", serValidM, 1'b0);
        checkVal("midRstBusy",  busyM,     1'b0);
        checkVal("midRstReady", inReadyM,  1'b0);
        reset = 1'b1;
        validSeen = 0;
        for (int i = 0; i < 12; i++) step();
        checkVal("noBitsAfterRst", validSeen, 0);

        // Quiet line.
        validSeen = 0;
        frameSeen = 0;
        for (int i = 0; i < 10; i++) step();
        checkVal("idleValid", validSeen, 0);
        checkVal("idleFrame", frameSeen, 0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            reset = ($urandom_range(0, 99) != 0);
            applyStimulus(($urandom_range(0, 99) < 60), WIDTH'($urandom));
            step();
        end
        reset = 1'b1;
        waitIdle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
